// File: rtl/pipeline_stage_register_if.sv
// pipeline_stage_register_if: handshake, hazard-control and payload bundle for one stage boundary
interface pipeline_stage_register_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int CTRL_WIDTH  = 4,
  parameter int COUNT_WIDTH = 16
);
  logic                   stall;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [CTRL_WIDTH-1:0]  ctrl_in;
  logic [DATA_WIDTH-1:0]  data_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [CTRL_WIDTH-1:0]  ctrl_out;
  logic [DATA_WIDTH-1:0]  data_out;
  logic [COUNT_WIDTH-1:0] killed_count;
  modport master (
    output stall, flush, in_valid, ctrl_in, data_in, out_ready,
    input  in_ready, out_valid, ctrl_out, data_out, killed_count
  );
  modport slave (
    input  stall, flush, in_valid, ctrl_in, data_in, out_ready,
    output in_ready, out_valid, ctrl_out, data_out, killed_count
  );
endinterface

// File: rtl/pipeline_stage_register.sv
// pipeline_stage_register: handshaked stage register with stall, flush-to-bubble and saturating kill count
// Defining PIPELINE_SKID_BUFFER_EN adds a one-entry skid so in_ready depends on registered state only
module pipeline_stage_register #(
  parameter int DATA_WIDTH  = 32,
  parameter int CTRL_WIDTH  = 4,
  parameter int COUNT_WIDTH = 16
) (
  input logic                     clk,
  input logic                     reset_n,
  pipeline_stage_register_if.slave bus
);
  logic                   out_valid_q, out_valid_d;
  logic [CTRL_WIDTH-1:0]  ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH:0]   count_sum;
  logic                   skid_valid_q;
  logic [1:0]             kill_n;
  logic                   in_xfer, drain;
  logic                   src_valid;
  logic [CTRL_WIDTH-1:0]  src_ctrl;
  logic [DATA_WIDTH-1:0]  src_data;
`ifdef PIPELINE_SKID_BUFFER_EN
  logic                   skid_valid_d;
  logic [CTRL_WIDTH-1:0]  skid_ctrl_q, skid_ctrl_d;
  logic [DATA_WIDTH-1:0]  skid_data_q, skid_data_d;
  assign bus.in_ready = !bus.stall && !bus.flush && !skid_valid_q;
  // A pending skid entry always wins the output slot; in_ready is low then, so no input competes
  assign src_valid = skid_valid_q || in_xfer;
  assign src_ctrl  = skid_valid_q ? skid_ctrl_q : bus.ctrl_in;
  assign src_data  = skid_valid_q ? skid_data_q : bus.data_in;
  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    if (bus.flush || (drain && skid_valid_q)) skid_valid_d = 1'b0;
    else if (in_xfer && !drain) begin
      skid_valid_d = 1'b1;
      skid_ctrl_d  = bus.ctrl_in;
      skid_data_d  = bus.data_in;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
    end
  end
`else
  assign skid_valid_q = 1'b0;
  assign bus.in_ready = !bus.stall && !bus.flush && (!out_valid_q || bus.out_ready);
  assign src_valid    = in_xfer;
  assign src_ctrl     = bus.ctrl_in;
  assign src_data     = bus.data_in;
`endif
  assign in_xfer   = bus.in_valid && bus.in_ready;
  assign drain     = !out_valid_q || bus.out_ready;
  assign kill_n    = {1'b0, out_valid_q} + {1'b0, skid_valid_q};
  assign count_sum = {1'b0, count_q} + {{(COUNT_WIDTH-1){1'b0}}, kill_n};
  // An empty output slot holds zero ctrl so a bubble decodes as a NOP downstream
  always_comb begin
    out_valid_d = out_valid_q;
    ctrl_d      = ctrl_q;
    data_d      = data_q;
    count_d     = count_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
      ctrl_d      = '0;
      data_d      = '0;
      count_d     = count_sum[COUNT_WIDTH] ? '1 : count_sum[COUNT_WIDTH-1:0];
    end else if (drain) begin
      out_valid_d = src_valid;
      ctrl_d      = src_valid ? src_ctrl : '0;
      data_d      = src_valid ? src_data : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      data_q      <= '0;
      count_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      data_q      <= data_d;
      count_q     <= count_d;
    end
  end
  assign bus.out_valid    = out_valid_q;
  assign bus.ctrl_out     = ctrl_q;
  assign bus.data_out     = data_q;
  assign bus.killed_count = count_q;
endmodule

// File: tb/tb_pipeline_stage_register.sv
// tb_pipeline_stage_register: directed scenarios plus random traffic against a queue-based model
module tb_pipeline_stage_register;
`ifdef PIPELINE_SKID_BUFFER_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  typedef struct {
    logic [3:0]  c;
    logic [31:0] d;
  } ent_t;
  logic clk = 1'b0;
  logic rst_n;
  int total = 0;
  int bad = 0;
  ent_t mq[$];
  int unsigned mk;
  logic exp_rdy, act_rdy;
  always #5 clk = ~clk;
  pipeline_stage_register_if #(.DATA_WIDTH(32), .CTRL_WIDTH(4), .COUNT_WIDTH(16)) bus();
  pipeline_stage_register_if #(.DATA_WIDTH(32), .CTRL_WIDTH(4), .COUNT_WIDTH(2)) sbus();
  pipeline_stage_register #(.DATA_WIDTH(32), .CTRL_WIDTH(4), .COUNT_WIDTH(16)) dut (
    .clk(clk), .reset_n(rst_n), .bus(bus));
  pipeline_stage_register #(.DATA_WIDTH(32), .CTRL_WIDTH(4), .COUNT_WIDTH(2)) sat (
    .clk(clk), .reset_n(rst_n), .bus(sbus));
  // Stage modelled as an ordered queue of live instructions, capacity 1 (2 with skid)
  task automatic tick();
    int unsigned s;
    exp_rdy = !bus.stall && !bus.flush &&
              (SKID ? (mq.size() < 2) : (mq.size() == 0 || bus.out_ready));
    @(negedge clk);
    act_rdy = bus.in_ready;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      mk = 0;
    end else if (bus.flush) begin
      s = mk + mq.size();
      mk = (s > 65535) ? 65535 : s;
      mq.delete();
    end else begin
      if (mq.size() > 0 && bus.out_ready) void'(mq.pop_front());
      if (bus.in_valid && exp_rdy) mq.push_back('{c: bus.ctrl_in, d: bus.data_in});
    end
    #1;
  endtask
  task automatic set_in(input logic v, input logic [3:0] c, input logic [31:0] d);
    bus.in_valid = v;
    bus.ctrl_in  = c;
    bus.data_in  = d;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    bus.stall = 0; bus.flush = 0; bus.out_ready = 0;
    set_in(1'b1, 4'hF, 32'hDEADBEEF);
    tick();
    tick();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", bus.out_valid);
    else total += 0;
    if (bus.out_valid !== 1'b0) bad++;
    total++; if (bus.data_out !== 32'h0) begin bad++; $display("FAIL reset_data: got %h exp 0", bus.data_out); end
    total++; if (bus.ctrl_out !== 4'h0) begin bad++; $display("FAIL reset_ctrl: got %h exp 0", bus.ctrl_out); end
    total++; if (bus.killed_count !== 16'h0) begin bad++; $display("FAIL reset_killed: got %0d exp 0", bus.killed_count); end
    total++; if (sbus.killed_count !== 2'h0) begin bad++; $display("FAIL reset_sat_killed: got %0d exp 0", sbus.killed_count); end
    total++; if (act_rdy !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b exp 1", act_rdy); end
    rst_n = 1'b1;
    tick();
    total++; if (bus.out_valid !== 1'b1 || bus.data_out !== 32'hDEADBEEF)
      begin bad++; $display("FAIL first_accept: got v=%b d=%h exp v=1 d=deadbeef", bus.out_valid, bus.data_out); end
  endtask
  task automatic test_stream();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      set_in(1'b1, 4'(i), 32'(i));
      tick();
      total++; if (act_rdy !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d]: got %b exp 1", i, act_rdy); end
      total++; if (bus.out_valid !== 1'b1 || bus.data_out !== 32'(i) || bus.ctrl_out !== 4'(i))
        begin bad++; $display("FAIL stream_out[%0d]: got v=%b d=%0h c=%0h exp v=1 d=%0h", i, bus.out_valid, bus.data_out, bus.ctrl_out, i); end
    end
    set_in(1'b0, 4'h0, 32'h0);
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain: got %b exp 0", bus.out_valid); end
  endtask
  task automatic test_backpressure();
    bus.out_ready = 1'b1;
    set_in(1'b1, 4'h1, 32'hA);
    tick();
    set_in(1'b1, 4'h2, 32'hB);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (act_rdy !== (SKID && k == 0)) begin bad++; $display("FAIL bp_ready[%0d]: got %b exp %b", k, act_rdy, SKID && k == 0); end
      total++; if (bus.out_valid !== 1'b1 || bus.data_out !== 32'hA)
        begin bad++; $display("FAIL bp_hold[%0d]: got v=%b d=%0h exp v=1 d=a", k, bus.out_valid, bus.data_out); end
    end
    bus.out_ready = 1'b1;
    tick();
    total++; if (bus.out_valid !== 1'b1 || bus.data_out !== 32'hB || bus.ctrl_out !== 4'h2)
      begin bad++; $display("FAIL bp_release: got v=%b d=%0h c=%0h exp v=1 d=b c=2", bus.out_valid, bus.data_out, bus.ctrl_out); end
    set_in(1'b0, 4'h0, 32'h0);
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup: got %b exp 0", bus.out_valid); end
  endtask
  task automatic test_stall();
    bus.out_ready = 1'b0;
    set_in(1'b1, 4'h3, 32'hC);
    tick();
    bus.stall = 1'b1;
    bus.out_ready = 1'b1;
    set_in(1'b1, 4'h4, 32'hD);
    for (int k = 0; k < 2; k++) begin
      tick();
      total++; if (act_rdy !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d]: got %b exp 0", k, act_rdy); end
      total++; if (bus.out_valid !== 1'b0 || bus.ctrl_out !== 4'h0)
        begin bad++; $display("FAIL stall_drain[%0d]: got v=%b c=%0h exp v=0 c=0", k, bus.out_valid, bus.ctrl_out); end
    end
    bus.stall = 1'b0;
    tick();
    total++; if (bus.out_valid !== 1'b1 || bus.data_out !== 32'hD)
      begin bad++; $display("FAIL stall_resume: got v=%b d=%0h exp v=1 d=d", bus.out_valid, bus.data_out); end
    set_in(1'b0, 4'h0, 32'h0);
    tick();
  endtask
  task automatic test_flush();
    bus.out_ready = 1'b0;
    set_in(1'b1, 4'b1011, 32'hE);
    tick();
    total++; if (bus.ctrl_out !== 4'b1011) begin bad++; $display("FAIL flush_pre: got %b exp 1011", bus.ctrl_out); end
    bus.flush = 1'b1;
    set_in(1'b1, 4'h7, 32'hF);
    tick();
    total++; if (act_rdy !== 1'b0) begin bad++; $display("FAIL flush_ready: got %b exp 0", act_rdy); end
    total++; if (bus.out_valid !== 1'b0 || bus.ctrl_out !== 4'h0 || bus.data_out !== 32'h0)
      begin bad++; $display("FAIL flush_bubble: got v=%b c=%0h d=%0h exp 0 0 0", bus.out_valid, bus.ctrl_out, bus.data_out); end
    total++; if (bus.killed_count !== 16'd1) begin bad++; $display("FAIL flush_killed: got %0d exp 1", bus.killed_count); end
    bus.flush = 1'b0;
    if (SKID) begin
      set_in(1'b1, 4'h5, 32'h11);
      tick();
      set_in(1'b1, 4'h6, 32'h22);
      tick();
      bus.flush = 1'b1;
      set_in(1'b0, 4'h0, 32'h0);
      tick();
      bus.flush = 1'b0;
      total++; if (bus.killed_count !== 16'd3) begin bad++; $display("FAIL flush_skid_killed: got %0d exp 3", bus.killed_count); end
    end
    set_in(1'b0, 4'h0, 32'h0);
    tick();
  endtask
  task automatic test_saturation();
    for (int i = 1; i <= 5; i++) begin
      sbus.in_valid = 1'b1;
      sbus.ctrl_in = 4'h1;
      sbus.data_in = 32'(i);
      tick();
      sbus.in_valid = 1'b0;
      sbus.flush = 1'b1;
      tick();
      sbus.flush = 1'b0;
      total++; if (sbus.killed_count !== 2'((i > 3) ? 3 : i))
        begin bad++; $display("FAIL sat_killed[%0d]: got %0d exp %0d", i, sbus.killed_count, (i > 3) ? 3 : i); end
    end
  endtask
  task automatic test_random();
    logic [3:0] ec;
    for (int n = 0; n < 400; n++) begin
      bus.stall = ($urandom_range(5) == 0);
      bus.flush = ($urandom_range(11) == 0);
      bus.out_ready = ($urandom_range(3) != 0);
      set_in(1'($urandom_range(1)), 4'($urandom), $urandom);
      tick();
      ec = (mq.size() > 0) ? mq[0].c : 4'h0;
      total++; if (act_rdy !== exp_rdy) begin bad++; $display("FAIL rnd_ready[%0d]: got %b exp %b", n, act_rdy, exp_rdy); end
      total++; if (bus.out_valid !== (mq.size() > 0)) begin bad++; $display("FAIL rnd_valid[%0d]: got %b exp %b", n, bus.out_valid, mq.size() > 0); end
      total++; if (bus.ctrl_out !== ec) begin bad++; $display("FAIL rnd_ctrl[%0d]: got %0h exp %0h", n, bus.ctrl_out, ec); end
      if (mq.size() > 0) begin
        total++; if (bus.data_out !== mq[0].d) begin bad++; $display("FAIL rnd_data[%0d]: got %0h exp %0h", n, bus.data_out, mq[0].d); end
      end
      total++; if (bus.killed_count !== 16'(mk)) begin bad++; $display("FAIL rnd_killed[%0d]: got %0d exp %0d", n, bus.killed_count, mk); end
    end
  endtask
  initial begin
    sbus.stall = 0; sbus.flush = 0; sbus.in_valid = 0; sbus.out_ready = 0;
    sbus.ctrl_in = 0; sbus.data_in = 0;
    mk = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_flush();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
